param_up_dn_counter: RTL and testbench

Parametrised up/down counter, the next generation of the team's 5-bit load/up/down counter. Adds configurable width and count bounds, a per-cycle step size, a run-time saturate/wrap mode select, a count enable, synchronous clear, and one-cycle event pulses for wrap and saturation. All outputs are registered. It is the general-purpose bounded counter for timers, occupancy trackers and address generators.

---
 rtl/param_up_dn_counter_if.sv | 32 +++
 rtl/param_up_dn_counter.sv | 114 +++++++++++
 tb/tb_param_up_dn_counter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/param_up_dn_counter_if.sv
// Control and status bundle for param_up_dn_counter.
// The master side drives the count requests and observes the registered
// count and event flags. The slave side is the counter itself.
interface param_up_dn_counter_if #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STEP_W = 3
);
    logic              Clear;
    logic              Load;
    logic [WIDTH-1:0]  IN;
    logic              En;
    logic              Up;
    logic              Down;
    logic [STEP_W-1:0] Step;
    logic              Wrap_Mode;

    logic [WIDTH-1:0]  Counter;
    logic              High;
    logic              Low;
    logic              Wrapped;
    logic              Sat;

    modport master (
        output Clear, Load, IN, En, Up, Down, Step, Wrap_Mode,
        input  Counter, High, Low, Wrapped, Sat
    );

    modport slave (
        input  Clear, Load, IN, En, Up, Down, Step, Wrap_Mode,
        output Counter, High, Low, Wrapped, Sat
    );
endinterface

// File: rtl/param_up_dn_counter.sv
// Bounded up/down counter with configurable width, bounds, step size and a
// run-time choice between saturating and wrapping at the bounds.
// Every output is registered; High/Low are derived from the next-state value
// so they always line up with Counter. Wrapped and Sat are one-cycle pulses
// describing the update that just happened.
module param_up_dn_counter #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 31,
    parameter int unsigned RST_VAL = 0,
    parameter int unsigned STEP_W  = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    param_up_dn_counter_if.slave   bus
);
    // One extra bit everywhere so that Counter+S and Counter+RANGE never alias.
    localparam int unsigned XW = WIDTH + 1;
    // Wide enough for both the step input and the range, so the step clamp
    // compares full values even when STEP_W exceeds the counter width.
    localparam int unsigned CW = (STEP_W > XW) ? STEP_W : XW;

    localparam logic [WIDTH:0] MIN_X   = XW'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X   = XW'(MAX_VAL);
    localparam logic [WIDTH:0] RST_X   = XW'(RST_VAL);
    localparam logic [WIDTH:0] ONE_X   = XW'(1);
    localparam logic [WIDTH:0] RANGE_X = MAX_X - MIN_X + ONE_X;

    logic [WIDTH:0]  cnt_x;
    logic [WIDTH:0]  in_x;
    logic [CW-1:0]   step_x;
    logic [WIDTH:0]  s_eff;
    logic [WIDTH:0]  sum_x;
    logic            up_over;
    logic            dn_under;
    logic [WIDTH:0]  nxt_x;
    logic            wrap_nxt;
    logic            sat_nxt;

    // Effective step and the bound-crossing tests for both directions.
    always_comb begin
        cnt_x    = {1'b0, bus.Counter};
        in_x     = {1'b0, bus.IN};
        step_x   = CW'(bus.Step);
        s_eff    = (step_x > CW'(RANGE_X)) ? RANGE_X : XW'(bus.Step);
        sum_x    = cnt_x + s_eff;
        up_over  = (sum_x > MAX_X);
        // Compare against MIN+S instead of subtracting, so no borrow is needed.
        dn_under = (cnt_x < (MIN_X + s_eff));
    end

    // Next-state selection in priority order: clear, load, down, up, hold.
    always_comb begin
        nxt_x    = cnt_x;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;

        if (bus.Clear) begin
            nxt_x = RST_X;
        end else if (bus.Load) begin
            // Out-of-range loads are clamped silently; Sat is reserved for counting.
            if (in_x < MIN_X) begin
                nxt_x = MIN_X;
            end else if (in_x > MAX_X) begin
                nxt_x = MAX_X;
            end else begin
                nxt_x = in_x;
            end
        end else if (bus.En && (bus.Down || bus.Up) && (s_eff != '0)) begin
            if (bus.Down) begin
                if (dn_under) begin
                    if (bus.Wrap_Mode) begin
                        nxt_x    = cnt_x + RANGE_X - s_eff;
                        wrap_nxt = 1'b1;
                    end else begin
                        nxt_x   = MIN_X;
                        sat_nxt = 1'b1;
                    end
                end else begin
                    nxt_x = cnt_x - s_eff;
                end
            end else begin
                if (up_over) begin
                    if (bus.Wrap_Mode) begin
                        nxt_x    = sum_x - RANGE_X;
                        wrap_nxt = 1'b1;
                    end else begin
                        nxt_x   = MAX_X;
                        sat_nxt = 1'b1;
                    end
                end else begin
                    nxt_x = sum_x;
                end
            end
        end
    end

    // Count register with bound flags and event pulses, all updated together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.Counter <= RST_X[WIDTH-1:0];
            bus.High    <= (RST_X == MAX_X);
            bus.Low     <= (RST_X == MIN_X);
            bus.Wrapped <= 1'b0;
            bus.Sat     <= 1'b0;
        end else begin
            bus.Counter <= nxt_x[WIDTH-1:0];
            bus.High    <= (nxt_x == MAX_X);
            bus.Low     <= (nxt_x == MIN_X);
            bus.Wrapped <= wrap_nxt;
            bus.Sat     <= sat_nxt;
        end
    end
endmodule

// File: tb/tb_param_up_dn_counter.sv
// Directed bench for param_up_dn_counter. Four instances cover the default
// configuration and the narrowed/widened bound cases. Stimulus pushes the
// expected post-edge state into a queue; a monitor pops and compares it on
// the falling edge after the update.
module tb_param_up_dn_counter;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    param_up_dn_counter_if #(.WIDTH(5), .STEP_W(3)) ifa ();
    param_up_dn_counter_if #(.WIDTH(5), .STEP_W(3)) ifb ();
    param_up_dn_counter_if #(.WIDTH(5), .STEP_W(3)) ifc ();
    param_up_dn_counter_if #(.WIDTH(8), .STEP_W(3)) ifd ();

    param_up_dn_counter #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(31), .RST_VAL(0), .STEP_W(3))
        dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
    param_up_dn_counter #(.WIDTH(5), .MIN_VAL(3), .MAX_VAL(12), .RST_VAL(3), .STEP_W(3))
        dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));
    param_up_dn_counter #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(20), .RST_VAL(0), .STEP_W(3))
        dut_c (.CLK(CLK), .RST(RST), .bus(ifc.slave));
    param_up_dn_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(5), .RST_VAL(0), .STEP_W(3))
        dut_d (.CLK(CLK), .RST(RST), .bus(ifd.slave));

    typedef struct {
        int          tag;
        int          d;
        int unsigned cnt;
        bit          hi;
        bit          lo;
        bit          wr;
        bit          sat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic compare(input exp_t e);
        int unsigned c;
        bit hi, lo, wr, sat;
        c = 0; hi = 0; lo = 0; wr = 0; sat = 0;
        case (e.d)
            0: begin c = 32'(ifa.Counter); hi = ifa.High; lo = ifa.Low; wr = ifa.Wrapped; sat = ifa.Sat; end
            1: begin c = 32'(ifb.Counter); hi = ifb.High; lo = ifb.Low; wr = ifb.Wrapped; sat = ifb.Sat; end
            2: begin c = 32'(ifc.Counter); hi = ifc.High; lo = ifc.Low; wr = ifc.Wrapped; sat = ifc.Sat; end
            default: begin c = 32'(ifd.Counter); hi = ifd.High; lo = ifd.Low; wr = ifd.Wrapped; sat = ifd.Sat; end
        endcase
        checks++;
        if (c !== e.cnt || hi !== e.hi || lo !== e.lo || wr !== e.wr || sat !== e.sat) begin
            failures++;
            $display("FAIL %s: got cnt=%0d high=%0b low=%0b wrapped=%0b sat=%0b, expected cnt=%0d high=%0b low=%0b wrapped=%0b sat=%0b",
                     e.name, c, hi, lo, wr, sat, e.cnt, e.hi, e.lo, e.wr, e.sat);
        end
    endtask

    task automatic check_now(input int d, input int unsigned cnt, input bit hi, lo, wr, sat,
                             input string name);
        exp_t e;
        e.tag = cyc; e.d = d; e.cnt = cnt; e.hi = hi; e.lo = lo; e.wr = wr; e.sat = sat; e.name = name;
        compare(e);
    endtask

    // Monitor: every entry whose target cycle has arrived is checked now.
    initial begin
        forever begin
            @(negedge CLK);
            while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
                compare(sbq.pop_front());
            end
        end
    end

    task automatic idle_all();
        ifa.Clear = 0; ifa.Load = 0; ifa.IN = '0; ifa.En = 0; ifa.Up = 0; ifa.Down = 0; ifa.Step = '0; ifa.Wrap_Mode = 0;
        ifb.Clear = 0; ifb.Load = 0; ifb.IN = '0; ifb.En = 0; ifb.Up = 0; ifb.Down = 0; ifb.Step = '0; ifb.Wrap_Mode = 0;
        ifc.Clear = 0; ifc.Load = 0; ifc.IN = '0; ifc.En = 0; ifc.Up = 0; ifc.Down = 0; ifc.Step = '0; ifc.Wrap_Mode = 0;
        ifd.Clear = 0; ifd.Load = 0; ifd.IN = '0; ifd.En = 0; ifd.Up = 0; ifd.Down = 0; ifd.Step = '0; ifd.Wrap_Mode = 0;
    endtask

    // One clock of stimulus on instance d plus the state expected after the edge.
    task automatic cyc_op(input int d, input bit clr, ld, input int unsigned inval,
                          input bit en, up, dn, input int unsigned st, input bit wm,
                          input int unsigned ec, input bit ehi, elo, ewr, esat,
                          input string name);
        exp_t e;
        @(negedge CLK);
        #1;
        idle_all();
        case (d)
            0: begin ifa.Clear = clr; ifa.Load = ld; ifa.IN = inval[4:0]; ifa.En = en; ifa.Up = up;
                     ifa.Down = dn; ifa.Step = st[2:0]; ifa.Wrap_Mode = wm; end
            1: begin ifb.Clear = clr; ifb.Load = ld; ifb.IN = inval[4:0]; ifb.En = en; ifb.Up = up;
                     ifb.Down = dn; ifb.Step = st[2:0]; ifb.Wrap_Mode = wm; end
            2: begin ifc.Clear = clr; ifc.Load = ld; ifc.IN = inval[4:0]; ifc.En = en; ifc.Up = up;
                     ifc.Down = dn; ifc.Step = st[2:0]; ifc.Wrap_Mode = wm; end
            default: begin ifd.Clear = clr; ifd.Load = ld; ifd.IN = inval[7:0]; ifd.En = en; ifd.Up = up;
                     ifd.Down = dn; ifd.Step = st[2:0]; ifd.Wrap_Mode = wm; end
        endcase
        e.tag = cyc + 1; e.d = d; e.cnt = ec; e.hi = ehi; e.lo = elo; e.wr = ewr; e.sat = esat; e.name = name;
        sbq.push_back(e);
    endtask

    initial begin
        RST = 1'b1;
        idle_all();
        #12;
        check_now(0, 0, 0, 1, 0, 0, "rst_a");
        check_now(1, 3, 0, 1, 0, 0, "rst_b");
        check_now(2, 0, 0, 1, 0, 0, "rst_c");
        check_now(3, 0, 0, 1, 0, 0, "rst_d");
        @(negedge CLK);
        RST = 1'b0;

        //     d clr ld  in  en up dn st wm   cnt hi lo wr sat
        cyc_op(0, 0, 1, 17, 0, 0, 0, 0, 0,   17, 0, 0, 0, 0, "a_load17");
        // Asynchronous reset mid-count, observed without a clock edge.
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_now(0, 0, 0, 1, 0, 0, "a_async_rst");
        idle_all();
        @(negedge CLK);
        #1;
        RST = 1'b0;

        // Saturate up from 29 with step 2.
        cyc_op(0, 0, 1, 29, 0, 0, 0, 0, 0,   29, 0, 0, 0, 0, "a_load29");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 2, 0,   31, 1, 0, 0, 0, "a_sat_up1");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 2, 0,   31, 1, 0, 0, 1, "a_sat_up2");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 2, 0,   31, 1, 0, 0, 1, "a_sat_up3");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 0, 0,   31, 1, 0, 0, 0, "a_step0_hold");
        // Priority: load over counting, then down over up.
        cyc_op(0, 0, 1, 9,  1, 1, 1, 1, 0,    9, 0, 0, 0, 0, "a_prio_load");
        cyc_op(0, 0, 0, 0,  1, 1, 1, 1, 0,    8, 0, 0, 0, 0, "a_down_beats_up");
        cyc_op(0, 0, 0, 0,  0, 1, 0, 1, 0,    8, 0, 0, 0, 0, "a_en0_hold");
        cyc_op(0, 0, 1, 5,  0, 0, 0, 0, 0,    5, 0, 0, 0, 0, "a_en0_load");
        // Back-to-back wraps in both directions.
        cyc_op(0, 0, 1, 30, 0, 0, 0, 0, 0,   30, 0, 0, 0, 0, "a_load30");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 3, 1,    1, 0, 0, 1, 0, "a_wrap_up");
        cyc_op(0, 0, 0, 0,  1, 0, 1, 3, 1,   30, 0, 0, 1, 0, "a_wrap_dn");
        cyc_op(0, 0, 0, 0,  1, 0, 1, 3, 1,   27, 0, 0, 0, 0, "a_dn_nowrap");
        // Saturate down, then clear drops the pulse.
        cyc_op(0, 0, 1, 1,  0, 0, 0, 0, 0,    1, 0, 0, 0, 0, "a_load1");
        cyc_op(0, 0, 0, 0,  1, 0, 1, 3, 0,    0, 0, 1, 0, 1, "a_sat_dn1");
        cyc_op(0, 0, 0, 0,  1, 0, 1, 3, 0,    0, 0, 1, 0, 1, "a_sat_dn2");
        cyc_op(0, 1, 0, 0,  1, 0, 1, 3, 0,    0, 0, 1, 0, 0, "a_clear");
        // Mode switch takes effect on the very next update.
        cyc_op(0, 0, 1, 31, 0, 0, 0, 0, 0,   31, 1, 0, 0, 0, "a_load31");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 1, 0,   31, 1, 0, 0, 1, "a_mode_sat");
        cyc_op(0, 0, 0, 0,  1, 1, 0, 1, 1,    0, 0, 1, 1, 0, "a_mode_wrap");

        // Bounds 3..12.
        cyc_op(1, 0, 1, 4,  0, 0, 0, 0, 1,    4, 0, 0, 0, 0, "b_load4");
        cyc_op(1, 0, 0, 0,  1, 0, 1, 3, 1,   11, 0, 0, 1, 0, "b_wrap_dn");
        cyc_op(1, 0, 0, 0,  0, 0, 0, 0, 1,   11, 0, 0, 0, 0, "b_pulse_drop");
        cyc_op(1, 0, 0, 0,  1, 1, 0, 7, 1,    8, 0, 0, 1, 0, "b_wrap_up");
        cyc_op(1, 0, 1, 0,  0, 0, 0, 0, 0,    3, 0, 1, 0, 0, "b_load_clamp_lo");
        cyc_op(1, 0, 1, 31, 0, 0, 0, 0, 0,   12, 1, 0, 0, 0, "b_load_clamp_hi");
        cyc_op(1, 0, 0, 0,  1, 1, 0, 7, 0,   12, 1, 0, 0, 1, "b_sat_at_max");

        // Upper bound 20: load clamp, then clear beats load.
        cyc_op(2, 0, 1, 30, 0, 0, 0, 0, 0,   20, 1, 0, 0, 0, "c_load_clamp");
        cyc_op(2, 1, 1, 7,  0, 0, 0, 0, 0,    0, 0, 1, 0, 0, "c_clear_beats_load");

        // Range 0..5 in 8 bits: step 7 is clamped to the range size 6.
        cyc_op(3, 0, 1, 2,  0, 0, 0, 0, 1,    2, 0, 0, 0, 0, "d_load2");
        cyc_op(3, 0, 0, 0,  1, 1, 0, 7, 1,    2, 0, 0, 1, 0, "d_step_clamp_up");
        cyc_op(3, 0, 0, 0,  1, 0, 1, 7, 1,    2, 0, 0, 1, 0, "d_step_clamp_dn");
        cyc_op(3, 0, 0, 0,  1, 1, 0, 7, 0,    5, 1, 0, 0, 1, "d_sat_up");

        @(negedge CLK);
        #1;
        idle_all();
        repeat (3) @(negedge CLK);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
